// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive sequencer.
package usb_rx_pkg;

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_WAIT, ERR} rx_state_t;

  // Decoded SYNC, LSB first on the wire: seven 0s then a 1.
  localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;
  localparam logic [2:0] STUFF_LIMIT  = 3'd6;

endpackage

// File: rtl/usb_rx_ctrl_if.sv
// Line, decoder and byte-stream signals between the receive sequencer and its neighbours.
interface usb_rx_ctrl_if;

  logic       d_plus;
  logic       dec_bit;
  logic       dec_eop;
  logic       bit_rcvd;
  logic       rx_active;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_done;
  logic       rx_error;

  modport master (
    input  d_plus, dec_bit, dec_eop,
    output bit_rcvd, rx_active, rx_data, rx_valid, rx_done, rx_error
  );

  modport slave (
    output d_plus, dec_bit, dec_eop,
    input  bit_rcvd, rx_active, rx_data, rx_valid, rx_done, rx_error
  );

endinterface

// File: rtl/usb_bit_timer.sv
// Bit-time recovery: sample counter resynchronised on every D+ edge, mid-bit strobe.
module usb_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned SAMPLE_PT    = CLKS_PER_BIT / 2 - 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_plus,
  input  logic enable,
  output logic fall,
  output logic bit_rcvd
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastCnt  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] SampleAt = CntW'(SAMPLE_PT);

  logic [CntW-1:0] cnt_q;
  logic            d_plus_q;
  logic            edge_det;

  assign edge_det = d_plus ^ d_plus_q;
  assign fall     = d_plus_q & ~d_plus;
  // An edge landing on the sample point wins: the bit is re-timed, not sampled.
  assign bit_rcvd = enable & ~edge_det & (cnt_q == SampleAt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      d_plus_q <= 1'b1;  // bus idles at J
    end else begin
      d_plus_q <= d_plus;
      if (edge_det || cnt_q == LastCnt) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_rx_ctrl.sv
// Receive sequencer: SYNC check, bit unstuffing, LSB-first byte assembly and EOP framing.
module usb_rx_ctrl
  import usb_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned SAMPLE_PT    = CLKS_PER_BIT / 2 - 1
) (
  input logic           clk,
  input logic           rst,
  usb_rx_ctrl_if.master bus
);

  rx_state_t  state_q;
  logic [2:0] bit_cnt_q;
  logic [2:0] ones_q;
  logic [7:0] shreg_q;
  logic       byte_seen_q;
  logic       consume_q;
  logic       rx_active_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       rx_done_q;
  logic       rx_error_q;
  logic       fall;
  logic       bit_rcvd;
  logic [7:0] shifted;

  usb_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SAMPLE_PT   (SAMPLE_PT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .d_plus  (bus.d_plus),
    .enable  (state_q != IDLE),
    .fall    (fall),
    .bit_rcvd(bit_rcvd)
  );

  assign shifted = {bus.dec_bit, shreg_q[7:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      ones_q      <= '0;
      shreg_q     <= '0;
      byte_seen_q <= 1'b0;
      consume_q   <= 1'b0;
      rx_active_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_done_q   <= 1'b0;
      rx_error_q  <= 1'b0;
    end else begin
      // Decoder output is registered on the strobe, so it is readable one cycle later.
      consume_q  <= bit_rcvd;
      rx_valid_q <= 1'b0;
      rx_done_q  <= 1'b0;
      rx_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fall) begin
            state_q     <= SYNC;
            bit_cnt_q   <= '0;
            ones_q      <= '0;
            byte_seen_q <= 1'b0;
          end
        end
        SYNC: begin
          if (consume_q) begin
            if (bus.dec_eop || (bus.dec_bit != SYNC_PATTERN[bit_cnt_q])) begin
              rx_error_q <= 1'b1;
              state_q    <= ERR;
            end else if (bit_cnt_q == 3'd7) begin
              rx_active_q <= 1'b1;
              state_q     <= DATA;
              bit_cnt_q   <= '0;
              ones_q      <= 3'd1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        DATA: begin
          if (consume_q) begin
            if (bus.dec_eop) begin
              state_q     <= EOP_WAIT;
              rx_active_q <= 1'b0;
              if (bit_cnt_q == 3'd0 && byte_seen_q) begin
                rx_done_q <= 1'b1;
              end else begin
                rx_error_q <= 1'b1;
              end
            end else if (ones_q == STUFF_LIMIT) begin
              if (bus.dec_bit) begin
                rx_error_q  <= 1'b1;
                rx_active_q <= 1'b0;
                state_q     <= ERR;
              end else begin
                ones_q <= '0;
              end
            end else begin
              shreg_q   <= shifted;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              ones_q    <= bus.dec_bit ? ones_q + 3'd1 : 3'd0;
              if (bit_cnt_q == 3'd7) begin
                rx_data_q   <= shifted;
                rx_valid_q  <= 1'b1;
                byte_seen_q <= 1'b1;
              end
            end
          end
        end
        EOP_WAIT: begin
          if (consume_q && !bus.dec_eop) begin
            state_q <= IDLE;
          end
        end
        ERR: begin
          rx_active_q <= 1'b0;
          if (consume_q && bus.dec_eop) begin
            state_q <= EOP_WAIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.bit_rcvd  = bit_rcvd;
  assign bus.rx_active = rx_active_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_done   = rx_done_q;
  assign bus.rx_error  = rx_error_q;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed bench: drives NRZI line symbols, models the decoder register, checks byte/framing strobes.
module tb_usb_rx_ctrl;

  localparam int CPB = 8;
  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  usb_rx_ctrl_if bus ();

  usb_rx_ctrl #(
    .CLKS_PER_BIT(CPB),
    .SAMPLE_PT   (CPB / 2 - 1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Line state and NRZI decoder model (sample on strobe, 1 = no transition).
  logic [1:0] line = LJ;
  logic [1:0] cur  = LJ;
  logic [1:0] dec_prev;
  assign bus.d_plus = line[1];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_prev    <= LJ;
      bus.dec_bit <= 1'b0;
      bus.dec_eop <= 1'b0;
    end else if (bus.bit_rcvd) begin
      bus.dec_bit <= (line == dec_prev);
      bus.dec_eop <= (line == LSE0);
      dec_prev    <= line;
    end
  end

  // Monitor, sampled on the falling edge.
  int cyc = 0, last_consume = 0, last_edge = 0;
  int n_valid = 0, n_done = 0, n_err = 0, n_active = 0, n_br = 0;
  int n_br_bad = 0, n_overlap = 0;
  int valid_lat = 0, done_lat = 0, err_lat = 0;
  int last_data = 0, valid_active = 0;
  logic br_prev = 1'b0, dp_prev = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (bus.d_plus != dp_prev) last_edge = cyc;
    dp_prev = bus.d_plus;
    if (br_prev) last_consume = cyc;
    if (bus.bit_rcvd) begin
      n_br++;
      if ((cyc - last_edge) < CPB && (cyc - last_edge) != CPB / 2) n_br_bad++;
    end
    br_prev = bus.bit_rcvd;
    if (bus.rx_active) n_active++;
    if (bus.rx_valid) begin
      n_valid++;
      last_data    = int'(bus.rx_data);
      valid_lat    = cyc - last_consume;
      valid_active = int'(bus.rx_active);
    end
    if (bus.rx_done) begin
      n_done++;
      done_lat = cyc - last_consume;
    end
    if (bus.rx_error) begin
      n_err++;
      err_lat = cyc - last_consume;
    end
    if (int'(bus.rx_valid) + int'(bus.rx_done) + int'(bus.rx_error) > 1) n_overlap++;
  end

  int tests = 0, fails = 0;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Symbol driver; with jitter on, edges wander by +/-1 clock around nominal.
  int jit = 0, jk = 0;
  task automatic sym(input logic [1:0] s);
    int len;
    line = s;
    len  = CPB;
    if (jit != 0) begin
      case (jk % 4)
        0:       len = CPB + 1;
        1:       len = CPB - 1;
        2:       len = CPB - 1;
        default: len = CPB + 1;
      endcase
      jk++;
    end
    repeat (len) @(posedge clk);
    #2;
  endtask

  task automatic nrzi(input logic b);
    if (!b) cur = (cur == LJ) ? LK : LJ;
    sym(cur);
  endtask

  int ones = 0;
  task automatic send_sync();
    for (int i = 0; i < 7; i++) nrzi(1'b0);
    nrzi(1'b1);
    ones = 1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      nrzi(d[i]);
      ones = d[i] ? ones + 1 : 0;
      if (ones == 6) begin
        nrzi(1'b0);
        ones = 0;
      end
    end
  endtask

  task automatic send_raw(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) nrzi(d[i]);
  endtask

  task automatic send_eop();
    sym(LSE0);
    sym(LSE0);
    cur = LJ;
    for (int i = 0; i < 4; i++) sym(LJ);
  endtask

  int b_valid, b_done, b_err, b_active, b_br;
  task automatic snap();
    b_valid  = n_valid;
    b_done   = n_done;
    b_err    = n_err;
    b_active = n_active;
    b_br     = n_br;
  endtask

  task automatic check_pkt(input string tag, input int valids, input int data,
                           input int dones, input int errs);
    check({tag, "_valid_cnt"}, n_valid - b_valid, valids);
    if (valids > 0) check({tag, "_data"}, last_data, data);
    check({tag, "_done_cnt"}, n_done - b_done, dones);
    check({tag, "_err_cnt"}, n_err - b_err, errs);
  endtask

  initial begin
    #1 rst = 1'b1;
    #20;
    check("rst_bit_rcvd",  int'(bus.bit_rcvd),  0);
    check("rst_rx_active", int'(bus.rx_active), 0);
    check("rst_rx_data",   int'(bus.rx_data),   0);
    check("rst_rx_valid",  int'(bus.rx_valid),  0);
    check("rst_rx_done",   int'(bus.rx_done),   0);
    check("rst_rx_error",  int'(bus.rx_error),  0);
    @(posedge clk);
    #2 rst = 1'b0;
    sym(LJ);
    sym(LJ);

    // Good packet carrying 8'hA5.
    snap();
    send_sync();
    send_byte(8'hA5);
    check("a5_active_mid", int'(bus.rx_active), 1);
    send_eop();
    check_pkt("a5", 1, 'hA5, 1, 0);
    check("a5_valid_lat", valid_lat, 1);
    check("a5_done_lat", done_lat, 1);
    check("a5_valid_active", valid_active, 1);
    check("a5_active_cycles", n_active - b_active, 72);
    check("a5_strobes", n_br - b_br, 19);
    check("a5_active_after", int'(bus.rx_active), 0);
    check("a5_data_held", int'(bus.rx_data), 'hA5);

    // 8'hFF needs one stuffed 0 after the fifth data bit.
    snap();
    send_sync();
    send_byte(8'hFF);
    send_eop();
    check_pkt("ff", 1, 'hFF, 1, 0);
    check("ff_active_cycles", n_active - b_active, 80);

    // Unstuffed run of ones: the sixth data 1 sits in a stuff slot.
    snap();
    send_sync();
    send_raw(8'hFF, 8);
    send_eop();
    check_pkt("stuff_err", 0, 0, 0, 1);
    check("stuff_err_lat", err_lat, 1);
    check("stuff_err_active_cycles", n_active - b_active, 48);

    // Three data bits then EOP: misaligned.
    snap();
    send_sync();
    send_raw(8'h05, 3);
    send_eop();
    check_pkt("misalign", 0, 0, 0, 1);
    check("misalign_err_lat", err_lat, 1);
    check("misalign_active_cycles", n_active - b_active, 32);

    // Corrupted SYNC (0,0,0,1,...), then a good packet.
    snap();
    send_raw(8'h88, 8);
    send_eop();
    check_pkt("badsync", 0, 0, 0, 1);
    check("badsync_active_cycles", n_active - b_active, 0);
    snap();
    send_sync();
    send_byte(8'h5A);
    send_eop();
    check_pkt("after_badsync", 1, 'h5A, 1, 0);

    // Reset after four data bits, then 8'h3C.
    snap();
    send_sync();
    send_raw(8'h3C, 4);
    check("prerst_active", int'(bus.rx_active), 1);
    rst = 1'b1;
    #1;
    check("midrst_bit_rcvd",  int'(bus.bit_rcvd),  0);
    check("midrst_rx_active", int'(bus.rx_active), 0);
    check("midrst_rx_data",   int'(bus.rx_data),   0);
    check("midrst_rx_valid",  int'(bus.rx_valid),  0);
    line = LJ;
    cur  = LJ;
    @(posedge clk);
    #2 rst = 1'b0;
    sym(LJ);
    sym(LJ);
    check_pkt("midrst", 0, 0, 0, 0);
    snap();
    send_sync();
    send_byte(8'h3C);
    send_eop();
    check_pkt("after_rst", 1, 'h3C, 1, 0);

    // Same traffic with edge jitter.
    jit = 1;
    snap();
    send_sync();
    send_byte(8'hA5);
    send_eop();
    check_pkt("jit_a5", 1, 'hA5, 1, 0);
    snap();
    send_sync();
    send_byte(8'hFF);
    send_eop();
    check_pkt("jit_ff", 1, 'hFF, 1, 0);
    jit = 0;

    check("strobe_overlap", n_overlap, 0);
    check("sample_latency", n_br_bad, 0);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
